ahb5_slave_mem: RTL

AHB5 subordinate (slave) endpoint with a byte-addressable local memory. It is the responder at the opposite end of our AHB5 master driver: it decodes address phases, inserts a configurable number of wait states and completes the data phase. It returns OKAY or the two-cycle ERROR response. It serves as the DUT-side model and the reference target for master VIP regressions in a single-subordinate system.

---
 rtl/ahb5_pkg.sv | 40 ++++
 rtl/ahb5_slave_byte_mem.sv | 38 +++
 rtl/ahb5_slave_mem.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb5_pkg.sv
// Shared AHB5 types and constants for the subordinate memory endpoint.
package ahb5_pkg;

  // Transfer type encoding on Htrans
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  // Transfer size encoding on Hsize (bytes = 2^Hsize)
  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3,
    SIZE_128   = 3'd4,
    SIZE_256   = 3'd5,
    SIZE_512   = 3'd6,
    SIZE_1024  = 3'd7
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Subordinate response FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slave_state_e;

  // Number of bytes moved by a transfer of the given Hsize
  function automatic int unsigned size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahb5_slave_byte_mem.sv
// Word-organised local memory with per-byte write enables and an
// asynchronous read port. Contents are deliberately not reset.
module ahb5_slave_byte_mem
  import ahb5_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  // Byte-granular write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read is combinational so a freshly committed write is visible in the
  // very next data phase
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate with byte-addressable local memory. Decodes address
// phases, inserts WAIT_STATES wait cycles on OKAY transfers and produces the
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  HReset,
  input  logic                  Hsel,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [1:0]            Htrans,
  input  logic                  Hwrite,
  input  logic [2:0]            Hsize,
  input  logic [2:0]            Hburst,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic                  Hready,
  output logic                  Hresp
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int LANE_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int WORDS  = MEM_BYTES / BYTES;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // FSM and data-phase state
  slave_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;

  // Address-phase decode
  logic                  xfer_valid;
  logic                  err_range;
  logic                  err_size;
  logic                  err_align;
  logic                  xfer_err;
  logic [ADDR_WIDTH-1:0] align_mask;

  // Data-phase lane selection and memory interface
  int                    lane_off;
  int                    lane_cnt;
  logic [BYTES-1:0]      lane_en;
  logic [DATA_WIDTH-1:0] lane_bits;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  // Burst type is accepted but every beat is decoded on its own address
  logic                  unused_burst;
  assign unused_burst = ^Hburst;

  // Classify the transfer presented in the current address phase
  always_comb begin
    xfer_valid = Hsel && ((Htrans == NONSEQ) || (Htrans == SEQ));
    align_mask = ADDR_WIDTH'(size_bytes(Hsize) - 32'd1);
    err_range  = {1'b0, Haddr} >= (ADDR_WIDTH + 1)'(MEM_BYTES);
    err_size   = Hsize > 3'(OFF_W);
    err_align  = (Haddr & align_mask) != '0;
    xfer_err   = err_range || err_size || err_align;
  end

  // Next-state logic: address phases are only accepted while Hready is high
  // (IDLE and ERR2); WAIT counts down, ERR1 always advances to ERR2
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    active_d = active_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    unique case (state_q)
      S_IDLE, S_ERR2: begin
        if (xfer_valid && xfer_err) begin
          // Errors never get wait states and never reach the memory
          state_d  = S_ERR1;
          hready_d = 1'b0;
          hresp_d  = HRESP_ERROR;
          active_d = 1'b0;
          cnt_d    = 4'd0;
        end else if (xfer_valid) begin
          addr_d   = Haddr;
          write_d  = Hwrite;
          size_d   = Hsize;
          active_d = 1'b1;
          hresp_d  = HRESP_OKAY;
          if (WAIT_STATES == 0) begin
            state_d  = S_IDLE;
            hready_d = 1'b1;
            cnt_d    = 4'd0;
          end else begin
            state_d  = S_WAIT;
            hready_d = 1'b0;
            cnt_d    = WAIT_LOAD;
          end
        end else begin
          // Deselected, IDLE or BUSY: zero-wait OKAY with no access
          state_d  = S_IDLE;
          hready_d = 1'b1;
          hresp_d  = HRESP_OKAY;
          active_d = 1'b0;
          cnt_d    = 4'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          // Following cycle completes the data phase
          state_d  = S_IDLE;
          hready_d = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      default: begin
        state_d  = S_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        active_d = 1'b0;
        cnt_d    = 4'd0;
      end
    endcase
  end

  // FSM register with registered Hready/Hresp
  always_ff @(posedge Hclk) begin
    if (HReset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      active_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
    end
  end

  // Little-endian lane window for the latched transfer
  always_comb begin
    lane_off = int'(addr_q[LANE_W-1:0]) & (BYTES - 1);
    lane_cnt = int'(size_bytes(size_q));
    lane_en  = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_en[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
    end
  end

  // Expand lane enables into a bit mask for read data
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_bits[gi*8 +: 8] = {8{lane_en[gi]}};
    end
  endgenerate

  assign word_idx = IDX_W'(addr_q >> OFF_W);

  // A write commits only on the completing edge of an OKAY data phase;
  // reset on that same edge aborts it
  assign mem_we = hready_q && active_q && write_q && !HReset;

  ahb5_slave_byte_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk  (Hclk),
    .we   (mem_we),
    .be   (lane_en),
    .waddr(word_idx),
    .wdata(Hwdata),
    .raddr(word_idx),
    .rdata(mem_rdata)
  );

  // Read data only in the completing cycle of an OKAY read; unselected
  // lanes are forced to zero
  assign Hrdata = (hready_q && active_q && !write_q) ? (mem_rdata & lane_bits) : '0;
  assign Hready = hready_q;
  assign Hresp  = hresp_q;

endmodule
